// File: rtl/mem_stage_access.sv
// mem_stage_access: consumer end of the EXE/MEM pipeline register.
// Decodes the memory-control field of the op held in the EXE latch and runs
// byte-wide memory/IO cycles on the 8-bit system bus (req/ack handshake).
// A 16-bit access is split into a low byte cycle at Result_in and a high
// byte cycle at Result_in+1. stall_out holds the upstream latches until the
// access completes; the result is presented to the MEM latch in DONE.
//
// Optional build macro: MEM_TIMEOUT_EN
//   Adds an 8-bit wait counter. After TIMEOUT unacknowledged bus cycles the
//   access is aborted, bus_err pulses for one cycle and reads return 16'hFFFF.
//   Without it the FSM waits indefinitely and bus_err is tied low.
//
// Ports:
//   CLK, RST                     clock, asynchronous active-high reset
//   *_in  (EXE latch side)       Wr_id, Fmask, MEMctrl, Flags, Result (address),
//                                Src1 (store data), seqNPC, EOI
//   stall_in                     MEM latch cannot accept this cycle
//   *_out (MEM latch side)       Wr_id, Fmask, MEMctrl, Flags, seqNPC, EOI,
//                                Data_out (load data or Result_in)
//   stall_out                    hold EXE and earlier latches
//   bus_req/we/io/addr/wdata     system bus request side (registered)
//   bus_ack/rdata                system bus response side
//   bus_err                      one-cycle pulse on an aborted access
module mem_stage_access #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [4:0]  Wr_id_in,
   input  logic [7:0]  Fmask_in,
   input  logic [6:0]  MEMctrl_in,
   input  logic [7:0]  Flags_in,
   input  logic [15:0] Result_in,
   input  logic [15:0] Src1_in,
   input  logic [15:0] seqNPC_in,
   input  logic        EOI_in,
   input  logic        stall_in,
   output logic [4:0]  Wr_id_out,
   output logic [7:0]  Fmask_out,
   output logic [6:0]  MEMctrl_out,
   output logic [7:0]  Flags_out,
   output logic [15:0] seqNPC_out,
   output logic        EOI_out,
   output logic [15:0] Data_out,
   output logic        stall_out,
   output logic        bus_req,
   output logic        bus_we,
   output logic        bus_io,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic        bus_ack,
   input  logic [7:0]  bus_rdata,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI, DONE} state_t;

   state_t      state_q, state_d;
   logic        access, is_wr, is_io, is_word;
   logic        req_d, we_d, io_d;
   logic [15:0] addr_d;
   logic [7:0]  wdata_d;
   logic [7:0]  lo_q, lo_d, hi_q, hi_d;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_W       = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q, to_d;
   logic             err_d;
`else
   // Parameter only matters with the timeout; keep it referenced.
   logic [7:0] unused_timeout;
   assign unused_timeout = 8'(TIMEOUT);
`endif

   // Memory-control decode; a write wins when both rd and wr bits are set.
   assign access  = |MEMctrl_in[3:0];
   assign is_wr   = MEMctrl_in[1] | MEMctrl_in[3];
   assign is_io   = MEMctrl_in[2] | MEMctrl_in[3];
   assign is_word = MEMctrl_in[4];

   // State and bus register bank.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_io    <= 1'b0;
         bus_addr  <= 16'h0000;
         bus_wdata <= 8'h00;
         lo_q      <= 8'h00;
         hi_q      <= 8'h00;
`ifdef MEM_TIMEOUT_EN
         cnt_q     <= '0;
         to_q      <= 1'b0;
         bus_err   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bus_req   <= req_d;
         bus_we    <= we_d;
         bus_io    <= io_d;
         bus_addr  <= addr_d;
         bus_wdata <= wdata_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q     <= cnt_d;
         to_q      <= to_d;
         bus_err   <= err_d;
`endif
      end
   end

`ifndef MEM_TIMEOUT_EN
   assign bus_err = 1'b0;
`endif

   // Next-state, bus launch/advance and stall generation.
   always_comb begin
      state_d   = state_q;
      req_d     = bus_req;
      we_d      = bus_we;
      io_d      = bus_io;
      addr_d    = bus_addr;
      wdata_d   = bus_wdata;
      lo_d      = lo_q;
      hi_d      = hi_q;
      stall_out = 1'b0;
`ifdef MEM_TIMEOUT_EN
      to_d      = to_q;
      err_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (access) begin
               stall_out = 1'b1;
               addr_d    = Result_in;
               wdata_d   = Src1_in[7:0];
               we_d      = is_wr;
               io_d      = is_io;
               req_d     = 1'b1;
               state_d   = REQ_LO;
`ifdef MEM_TIMEOUT_EN
               to_d      = 1'b0;
`endif
            end
         end
         REQ_LO: begin
            stall_out = 1'b1;
            if (bus_req && bus_ack) begin
               lo_d = bus_rdata;
               if (is_word) begin
                  // Address increment wraps within 16 bits.
                  addr_d  = Result_in + 16'd1;
                  wdata_d = Src1_in[15:8];
                  state_d = REQ_HI;
               end else begin
                  req_d   = 1'b0;
                  state_d = DONE;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               to_d    = 1'b1;
               state_d = DONE;
            end
`endif
         end
         REQ_HI: begin
            stall_out = 1'b1;
            if (bus_req && bus_ack) begin
               hi_d    = bus_rdata;
               req_d   = 1'b0;
               state_d = DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               to_d    = 1'b1;
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            // Downstream stall already freezes upstream; just hold the result.
            if (!stall_in) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef MEM_TIMEOUT_EN
      // Wait counter restarts on every state change.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (bus_req && !bus_ack) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
`endif
   end

   // Result selection toward the MEM latch.
   always_comb begin
      Data_out = Result_in;
      if (state_q == DONE && !is_wr) begin
         if (is_word) begin
            Data_out = {hi_q, lo_q};
         end else begin
            Data_out = {8'h00, lo_q};
         end
`ifdef MEM_TIMEOUT_EN
         if (to_q) begin
            Data_out = 16'hFFFF;
         end
`endif
      end
   end

   // Control fields become a bubble while upstream is held.
   assign Wr_id_out   = stall_out ? 5'd0 : Wr_id_in;
   assign Fmask_out   = stall_out ? 8'd0 : Fmask_in;
   assign MEMctrl_out = stall_out ? 7'd0 : MEMctrl_in;
   assign EOI_out     = stall_out ? 1'b0 : EOI_in;
   assign Flags_out   = Flags_in;
   assign seqNPC_out  = seqNPC_in;

endmodule

// File: tb/tb_mem_stage_access.sv
module tb_mem_stage_access;

   logic        CLK = 1'b0;
   logic        RST;
   logic [4:0]  Wr_id_in = '0;
   logic [7:0]  Fmask_in = '0;
   logic [6:0]  MEMctrl_in = '0;
   logic [7:0]  Flags_in = '0;
   logic [15:0] Result_in = '0;
   logic [15:0] Src1_in = '0;
   logic [15:0] seqNPC_in = '0;
   logic        EOI_in = 1'b0;
   logic        stall_in = 1'b0;
   logic [4:0]  Wr_id_out;
   logic [7:0]  Fmask_out;
   logic [6:0]  MEMctrl_out;
   logic [7:0]  Flags_out;
   logic [15:0] seqNPC_out;
   logic        EOI_out;
   logic [15:0] Data_out;
   logic        stall_out;
   logic        bus_req, bus_we, bus_io, bus_err;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_ack = 1'b0;
   logic [7:0]  bus_rdata = 8'h00;

   always #5 CLK = ~CLK;

   mem_stage_access dut (
      .CLK(CLK), .RST(RST),
      .Wr_id_in(Wr_id_in), .Fmask_in(Fmask_in), .MEMctrl_in(MEMctrl_in),
      .Flags_in(Flags_in), .Result_in(Result_in), .Src1_in(Src1_in),
      .seqNPC_in(seqNPC_in), .EOI_in(EOI_in), .stall_in(stall_in),
      .Wr_id_out(Wr_id_out), .Fmask_out(Fmask_out), .MEMctrl_out(MEMctrl_out),
      .Flags_out(Flags_out), .seqNPC_out(seqNPC_out), .EOI_out(EOI_out),
      .Data_out(Data_out), .stall_out(stall_out),
      .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   typedef struct {
      logic [6:0]  ctrl;
      logic [15:0] result;
      logic [15:0] src1;
      logic [4:0]  wr_id;
      logic [7:0]  lo;
      logic [7:0]  hi;
      int          waits;
      logic [15:0] exp_data;
      int          exp_phases;
      logic        exp_we;
      logic        exp_io;
   } vec_t;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        we;
      logic        io;
   } bus_t;

   typedef struct {
      logic [15:0] data;
      logic [4:0]  wr_id;
      logic [6:0]  ctrl;
      logic [7:0]  fmask;
      logic [7:0]  flags;
      logic [15:0] npc;
      logic        eoi;
   } exp_t;

   exp_t sb[$];
   bus_t blog[$];
   int   n_checks = 0;
   int   n_pass = 0;

   int         rsp_waits = 0;
   logic [7:0] rsp_lo = 8'h00;
   logic [7:0] rsp_hi = 8'h00;
   bit         rsp_hang = 1'b0;
   bit         rsp_spurious = 1'b0;
   int         rsp_phase = 0;
   int         rsp_wcnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Bus slave: acks after rsp_waits wait cycles per byte phase, logs each transfer.
   always @(negedge CLK) begin
      if (!bus_req) begin
         rsp_phase = 0;
         rsp_wcnt  = 0;
         bus_ack   = rsp_spurious;
      end else begin
         if (bus_ack) begin
            rsp_phase++;
            rsp_wcnt = 0;
         end
         bus_ack = 1'b0;
         if (!rsp_hang) begin
            if (rsp_wcnt == rsp_waits) begin
               bus_ack   = 1'b1;
               bus_rdata = (rsp_phase == 0) ? rsp_lo : rsp_hi;
               blog.push_back('{bus_addr, bus_wdata, bus_we, bus_io});
            end else begin
               rsp_wcnt++;
            end
         end
      end
   end

   task automatic drive_op(input logic [6:0] ctrl, input logic [15:0] result,
                           input logic [15:0] src1, input logic [4:0] wr_id);
      MEMctrl_in = ctrl;
      Result_in  = result;
      Src1_in    = src1;
      Wr_id_in   = wr_id;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          reqc = 0;
      bit          done = 1'b0;
      bit          stalled = 1'b0;
      int          b0;
      exp_t        e;
      logic [15:0] a1;
      @(posedge CLK); #1;
      b0 = blog.size();
      drive_op(v.ctrl, v.result, v.src1, v.wr_id);
      Fmask_in  = 8'h5A ^ 8'(idx);
      Flags_in  = 8'hC3 ^ 8'(idx);
      seqNPC_in = 16'h0100 + 16'(idx);
      EOI_in    = (idx % 2) == 1;
      rsp_waits = v.waits;
      rsp_lo    = v.lo;
      rsp_hi    = v.hi;
      sb.push_back('{v.exp_data, v.wr_id, v.ctrl, Fmask_in, Flags_in, seqNPC_in, EOI_in});
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge CLK);
         if (bus_req) reqc++;
         if (stall_out) begin
            if (!stalled) begin
               check($sformatf("v%0d bubble", idx), {Wr_id_out, Fmask_out, MEMctrl_out, EOI_out}, 0);
               stalled = 1'b1;
            end
         end else if (!stall_in) begin
            e = sb.pop_front();
            check($sformatf("v%0d data", idx), Data_out, e.data);
            check($sformatf("v%0d wr_id", idx), Wr_id_out, e.wr_id);
            check($sformatf("v%0d fields", idx), {MEMctrl_out, Fmask_out, Flags_out, EOI_out},
                  {e.ctrl, e.fmask, e.flags, e.eoi});
            check($sformatf("v%0d npc", idx), seqNPC_out, e.npc);
            done = 1'b1;
         end
      end
      if (!done) begin
         check($sformatf("v%0d completion timeout", idx), 0, 1);
         void'(sb.pop_front());
      end
      check($sformatf("v%0d stalled", idx), stalled, v.exp_phases > 0);
      check($sformatf("v%0d req cycles", idx), reqc, v.exp_phases * (v.waits + 1));
      check($sformatf("v%0d bus transfers", idx), blog.size() - b0, v.exp_phases);
      a1 = v.result + 16'd1;
      if (blog.size() - b0 >= 1 && v.exp_phases >= 1)
         check($sformatf("v%0d lo xfer", idx),
               {blog[b0].addr, blog[b0].wdata, blog[b0].we, blog[b0].io},
               {v.result, v.src1[7:0], v.exp_we, v.exp_io});
      if (blog.size() - b0 >= 2 && v.exp_phases >= 2)
         check($sformatf("v%0d hi xfer", idx),
               {blog[b0+1].addr, blog[b0+1].wdata, blog[b0+1].we, blog[b0+1].io},
               {a1, v.src1[15:8], v.exp_we, v.exp_io});
   endtask

   vec_t vecs[9];

   initial begin
      int b0;
      bit ok;
      int cnt_a, cnt_b;

      vecs[0] = '{7'h00, 16'h1234, 16'h0000, 5'd3,  8'h00, 8'h00, 0, 16'h1234, 0, 1'b0, 1'b0};
      vecs[1] = '{7'h01, 16'hC000, 16'h0000, 5'd7,  8'hA5, 8'h00, 2, 16'h00A5, 1, 1'b0, 1'b0};
      vecs[2] = '{7'h12, 16'hFFFF, 16'hBEEF, 5'd9,  8'h00, 8'h00, 0, 16'hFFFF, 2, 1'b1, 1'b0};
      vecs[3] = '{7'h11, 16'h1000, 16'h0000, 5'd4,  8'h34, 8'h12, 1, 16'h1234, 2, 1'b0, 1'b0};
      vecs[4] = '{7'h08, 16'h0040, 16'h55AA, 5'd5,  8'h00, 8'h00, 3, 16'h0040, 1, 1'b1, 1'b1};
      vecs[5] = '{7'h03, 16'h2222, 16'h0077, 5'd6,  8'h99, 8'h00, 0, 16'h2222, 1, 1'b1, 1'b0};
      vecs[6] = '{7'h64, 16'h0300, 16'h0000, 5'd8,  8'h7E, 8'h11, 1, 16'h007E, 1, 1'b0, 1'b1};
      vecs[7] = '{7'h60, 16'hABCD, 16'h0000, 5'd10, 8'h00, 8'h00, 0, 16'hABCD, 0, 1'b0, 1'b0};
      vecs[8] = '{7'h1C, 16'h8000, 16'h1357, 5'd11, 8'h00, 8'h00, 0, 16'h8000, 2, 1'b1, 1'b1};

      // Reset values.
      RST = 1'b1;
      #1;
      check("reset bus", {bus_req, bus_we, bus_io, bus_err, bus_addr, bus_wdata}, 0);
      check("reset stall", stall_out, 0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Word IO read held in DONE by downstream stall.
      @(posedge CLK); #1;
      b0 = blog.size();
      drive_op(7'h14, 16'h00BE, 16'h0000, 5'd12);
      rsp_waits = 0; rsp_lo = 8'h11; rsp_hi = 8'h22;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge CLK);
         if (!stall_out) ok = 1'b1;
      end
      check("hold reach done", ok, 1);
      stall_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check($sformatf("hold data %0d", k), Data_out, 16'h2211);
         check($sformatf("hold quiet %0d", k), {bus_req, stall_out, Wr_id_out}, {1'b0, 1'b0, 5'd12});
      end
      stall_in = 1'b0;
      check("hold transfers", blog.size() - b0, 2);
      if (blog.size() - b0 == 2)
         check("hold io xfers", {blog[b0].addr, blog[b0].io, blog[b0+1].addr, blog[b0+1].io},
               {16'h00BE, 1'b1, 16'h00BF, 1'b1});

      // Ack while no request is outstanding.
      @(posedge CLK); #1;
      drive_op(7'h00, 16'h4321, 16'h0000, 5'd1);
      rsp_spurious = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check($sformatf("spurious ack %0d", k), {bus_req, stall_out, Data_out}, {1'b0, 1'b0, 16'h4321});
      end
      rsp_spurious = 1'b0;
      @(negedge CLK);

      // Reset during the high byte cycle.
      @(posedge CLK); #1;
      b0 = blog.size();
      drive_op(7'h11, 16'h4000, 16'h0000, 5'd2);
      rsp_waits = 4; rsp_lo = 8'h01; rsp_hi = 8'h02;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge CLK);
         if (blog.size() > b0) ok = 1'b1;
      end
      check("rst reach lo ack", ok, 1);
      @(negedge CLK);
      check("rst in hi", {bus_req, bus_addr}, {1'b1, 16'h4001});
      #2 RST = 1'b1;
      #1;
      check("rst async", {bus_req, bus_err, bus_addr}, 0);
      @(negedge CLK);
      drive_op(7'h00, 16'h5555, 16'h0000, 5'd0);
      #1;
      check("rst idle", {stall_out, Data_out}, {1'b0, 16'h5555});
      @(negedge CLK);
      RST = 1'b0;

      // Slave never acks.
      @(posedge CLK); #1;
      rsp_hang = 1'b1;
      drive_op(7'h01, 16'h7000, 16'h0000, 5'd13);
`ifdef MEM_TIMEOUT_EN
      cnt_a = 0; cnt_b = 0; ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge CLK);
         if (bus_req) cnt_a++;
         if (bus_err) cnt_b++;
         if (!stall_out) ok = 1'b1;
      end
      check("timeout done", ok, 1);
      check("timeout req cycles", cnt_a, 64);
      check("timeout err pulses", cnt_b, 1);
      check("timeout data", Data_out, 16'hFFFF);
      @(posedge CLK); #1;
      drive_op(7'h00, 16'h0000, 16'h0000, 5'd0);
      @(negedge CLK);
      check("timeout err cleared", bus_err, 0);
`else
      cnt_a = 0; cnt_b = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge CLK);
         if (stall_out) cnt_a++;
         if (bus_err) cnt_b++;
      end
      check("hang stall cycles", cnt_a, 100);
      check("hang no err", cnt_b, 0);
`endif
      rsp_hang = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      drive_op(7'h00, 16'h0000, 16'h0000, 5'd0);
      @(negedge CLK);
      RST = 1'b0;

      // Pipeline still healthy afterwards.
      run_vec(vecs[3], 9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

endmodule
